// File: rtl/cc_comparator_side_tracker.sv
// Frog side-edge tracker.
// ORs NROWS matrix rows into a column-occupancy vector. Classifies the Frog as
// empty, right edge, left edge or middle. Tracks how long it dwells at an edge
// and emits edge-entry pulses plus an edge-hold flag.
// Optional feature macro: CC_COMPARATOR_SIDE_TRACKER_COLUMN_EN adds a registered
// lowest-occupied-column index output.
module cc_comparator_side_tracker #(
  parameter int unsigned DATAWIDTH_BUS = 8,
  parameter int unsigned NROWS         = 14,
  parameter int unsigned DWELL_CYCLES  = 3
) (
  input  logic                             CC_COMPARATOR_SIDE_TRACKER_CLOCK_50,
  input  logic                             CC_COMPARATOR_SIDE_TRACKER_RESET_InHigh,
  input  logic                             CC_COMPARATOR_SIDE_TRACKER_SAMPLE_InHigh,
  input  logic                             CC_COMPARATOR_SIDE_TRACKER_CLEAR_InHigh,
  input  logic [NROWS*DATAWIDTH_BUS-1:0]   CC_COMPARATOR_SIDE_TRACKER_ROWS_In_Bus,
  output logic [1:0]                       CC_COMPARATOR_SIDE_TRACKER_LOCATION_Out_Bus,
  output logic                             CC_COMPARATOR_SIDE_TRACKER_ENTER_RIGHT_Out,
  output logic                             CC_COMPARATOR_SIDE_TRACKER_ENTER_LEFT_Out,
`ifdef CC_COMPARATOR_SIDE_TRACKER_COLUMN_EN
  output logic [$clog2(DATAWIDTH_BUS)-1:0] CC_COMPARATOR_SIDE_TRACKER_COLUMN_Out_Bus,
`endif
  output logic                             CC_COMPARATOR_SIDE_TRACKER_HOLD_Out
);

  localparam int unsigned W   = DATAWIDTH_BUS;
  localparam int unsigned CW  = $clog2(DWELL_CYCLES + 1);
  localparam int unsigned CLW = $clog2(DATAWIDTH_BUS);

  localparam logic [W-1:0]  OCC_RIGHT = W'(1);
  localparam logic [W-1:0]  OCC_LEFT  = W'(1) << (W - 1);
  localparam logic [CW-1:0] DWELL_MAX = CW'(DWELL_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  // Encoding doubles as the LOCATION code.
  typedef enum logic [1:0] {
    S_EMPTY  = 2'b00,
    S_RIGHT  = 2'b01,
    S_LEFT   = 2'b10,
    S_MIDDLE = 2'b11
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            enter_right_q;
  logic            enter_left_q;
  logic            hold_q;

  logic [W-1:0]    occ;
  state_t          cls;
  logic            cls_is_edge;
  logic [CW-1:0]   cnt_d;
  logic [CLW-1:0]  col_d;

  // Column occupancy: OR of every row.
  always_comb begin
    occ = '0;
    for (int r = 0; r < int'(NROWS); r++) begin
      occ = occ | CC_COMPARATOR_SIDE_TRACKER_ROWS_In_Bus[r*W +: W];
    end
  end

  // Classify occupancy; a lone bit 0 is the right edge, a lone MSB the left edge.
  always_comb begin
    cls = S_MIDDLE;
    if (occ == '0) begin
      cls = S_EMPTY;
    end else if (occ == OCC_RIGHT) begin
      cls = S_RIGHT;
    end else if (occ == OCC_LEFT) begin
      cls = S_LEFT;
    end
    cls_is_edge = (cls == S_RIGHT) || (cls == S_LEFT);
  end

  // Next dwell count: saturating increment at the same edge, reload on a new edge.
  always_comb begin
    cnt_d = '0;
    if (cls_is_edge) begin
      if (cls == state_q) begin
        cnt_d = (cnt_q == DWELL_MAX) ? DWELL_MAX : cnt_q + CNT_ONE;
      end else begin
        cnt_d = CNT_ONE;
      end
    end
  end

  // Index of lowest occupied column, 0 when empty.
  always_comb begin
    col_d = '0;
    for (int i = int'(W) - 1; i >= 0; i--) begin
      if (occ[i]) begin
        col_d = CLW'(i);
      end
    end
  end

  // Tracker FSM with registered outputs; CLEAR beats SAMPLE.
  always_ff @(posedge CC_COMPARATOR_SIDE_TRACKER_CLOCK_50 or
              posedge CC_COMPARATOR_SIDE_TRACKER_RESET_InHigh) begin
    if (CC_COMPARATOR_SIDE_TRACKER_RESET_InHigh) begin
      state_q       <= S_EMPTY;
      cnt_q         <= '0;
      enter_right_q <= 1'b0;
      enter_left_q  <= 1'b0;
      hold_q        <= 1'b0;
    end else if (CC_COMPARATOR_SIDE_TRACKER_CLEAR_InHigh) begin
      state_q       <= S_EMPTY;
      cnt_q         <= '0;
      enter_right_q <= 1'b0;
      enter_left_q  <= 1'b0;
      hold_q        <= 1'b0;
    end else if (CC_COMPARATOR_SIDE_TRACKER_SAMPLE_InHigh) begin
      state_q       <= cls;
      cnt_q         <= cnt_d;
      enter_right_q <= (cls == S_RIGHT) && (state_q != S_RIGHT);
      enter_left_q  <= (cls == S_LEFT) && (state_q != S_LEFT);
      hold_q        <= (cnt_d == DWELL_MAX);
    end else begin
      enter_right_q <= 1'b0;
      enter_left_q  <= 1'b0;
    end
  end

`ifdef CC_COMPARATOR_SIDE_TRACKER_COLUMN_EN
  logic [CLW-1:0] col_q;

  // Column index follows the same reset/clear/sample rules as LOCATION.
  always_ff @(posedge CC_COMPARATOR_SIDE_TRACKER_CLOCK_50 or
              posedge CC_COMPARATOR_SIDE_TRACKER_RESET_InHigh) begin
    if (CC_COMPARATOR_SIDE_TRACKER_RESET_InHigh) begin
      col_q <= '0;
    end else if (CC_COMPARATOR_SIDE_TRACKER_CLEAR_InHigh) begin
      col_q <= '0;
    end else if (CC_COMPARATOR_SIDE_TRACKER_SAMPLE_InHigh) begin
      col_q <= col_d;
    end
  end

  assign CC_COMPARATOR_SIDE_TRACKER_COLUMN_Out_Bus = col_q;
`else
  logic unused_col;
  assign unused_col = ^col_d;
`endif

  assign CC_COMPARATOR_SIDE_TRACKER_LOCATION_Out_Bus = state_q;
  assign CC_COMPARATOR_SIDE_TRACKER_ENTER_RIGHT_Out  = enter_right_q;
  assign CC_COMPARATOR_SIDE_TRACKER_ENTER_LEFT_Out   = enter_left_q;
  assign CC_COMPARATOR_SIDE_TRACKER_HOLD_Out         = hold_q;

endmodule

// File: tb/tb_cc_comparator_side_tracker.sv
// Directed self-checking bench for cc_comparator_side_tracker (W=8, NROWS=14, DWELL=3).
module tb_cc_comparator_side_tracker;

  localparam int unsigned W     = 8;
  localparam int unsigned NROWS = 14;
  localparam int unsigned DWELL = 3;

  logic                 clk;
  logic                 rst;
  logic                 sample;
  logic                 clear;
  logic [NROWS*W-1:0]   rows;
  logic [1:0]           loc;
  logic                 enter_r;
  logic                 enter_l;
  logic                 hold;
`ifdef CC_COMPARATOR_SIDE_TRACKER_COLUMN_EN
  logic [$clog2(W)-1:0] column;
`endif

  int checks;
  int errors;

  cc_comparator_side_tracker #(
    .DATAWIDTH_BUS (W),
    .NROWS         (NROWS),
    .DWELL_CYCLES  (DWELL)
  ) dut (
    .CC_COMPARATOR_SIDE_TRACKER_CLOCK_50         (clk),
    .CC_COMPARATOR_SIDE_TRACKER_RESET_InHigh     (rst),
    .CC_COMPARATOR_SIDE_TRACKER_SAMPLE_InHigh    (sample),
    .CC_COMPARATOR_SIDE_TRACKER_CLEAR_InHigh     (clear),
    .CC_COMPARATOR_SIDE_TRACKER_ROWS_In_Bus      (rows),
    .CC_COMPARATOR_SIDE_TRACKER_LOCATION_Out_Bus (loc),
    .CC_COMPARATOR_SIDE_TRACKER_ENTER_RIGHT_Out  (enter_r),
    .CC_COMPARATOR_SIDE_TRACKER_ENTER_LEFT_Out   (enter_l),
`ifdef CC_COMPARATOR_SIDE_TRACKER_COLUMN_EN
    .CC_COMPARATOR_SIDE_TRACKER_COLUMN_Out_Bus   (column),
`endif
    .CC_COMPARATOR_SIDE_TRACKER_HOLD_Out         (hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rows(input int ra, input logic [7:0] va, input int rb, input logic [7:0] vb);
    rows = '0;
    if (ra >= 0) rows[ra*W +: W] = va;
    if (rb >= 0) rows[rb*W +: W] = rb == ra ? (va | vb) : vb;
  endtask

  task automatic test_reset();
    // Build up some state first: right edge, held.
    set_rows(5, 8'h01, -1, 8'h00);
    sample = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (hold !== 1'b1 || loc !== 2'b01) begin
      errors++;
      $display("FAIL reset_prep: loc=%b hold=%b required loc=01 hold=1", loc, hold);
    end
    // Assert reset mid-cycle; outputs must clear without a clock edge.
    #2 rst = 1'b1;
    #1;
    checks++;
    if (loc !== 2'b00 || enter_r !== 1'b0 || enter_l !== 1'b0 || hold !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: loc=%b er=%b el=%b hold=%b required all 0",
               loc, enter_r, enter_l, hold);
    end
    sample = 1'b0;
    tick();
    rst = 1'b0;
    tick(); tick();
    checks++;
    if (loc !== 2'b00 || hold !== 1'b0 || enter_r !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: loc=%b hold=%b er=%b required 00/0/0", loc, hold, enter_r);
    end
  endtask

  task automatic test_right_dwell();
    // Expected per clock: loc, enter_right, hold.
    logic [1:0] exp_loc [4] = '{2'b01, 2'b01, 2'b01, 2'b01};
    logic       exp_er  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic       exp_h   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    set_rows(5, 8'h01, -1, 8'h00);
    sample = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (loc !== exp_loc[i] || enter_r !== exp_er[i] || hold !== exp_h[i] || enter_l !== 1'b0) begin
        errors++;
        $display("FAIL right_dwell[%0d]: loc=%b er=%b el=%b hold=%b required %b/%b/0/%b",
                 i, loc, enter_r, enter_l, hold, exp_loc[i], exp_er[i], exp_h[i]);
      end
    end
  endtask

  task automatic test_middle();
    set_rows(2, 8'h80, 9, 8'h01);
    sample = 1'b1;
    tick();
    checks++;
    if (loc !== 2'b11 || enter_r !== 1'b0 || enter_l !== 1'b0 || hold !== 1'b0) begin
      errors++;
      $display("FAIL middle: loc=%b er=%b el=%b hold=%b required 11/0/0/0",
               loc, enter_r, enter_l, hold);
    end
  endtask

  task automatic test_jump();
    // Left, left, right, right, right: hold only on the third right sample.
    logic [7:0] vec     [5] = '{8'h80, 8'h80, 8'h01, 8'h01, 8'h01};
    logic [1:0] exp_loc [5] = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b01};
    logic       exp_el  [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       exp_er  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       exp_h   [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    sample = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_rows(7, vec[i], -1, 8'h00);
      tick();
      checks++;
      if (loc !== exp_loc[i] || enter_l !== exp_el[i] || enter_r !== exp_er[i] ||
          hold !== exp_h[i]) begin
        errors++;
        $display("FAIL jump[%0d]: loc=%b el=%b er=%b hold=%b required %b/%b/%b/%b",
                 i, loc, enter_l, enter_r, hold, exp_loc[i], exp_el[i], exp_er[i], exp_h[i]);
      end
    end
  endtask

  task automatic test_sample_low_clear();
    set_rows(0, 8'h80, -1, 8'h00);
    sample = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (loc !== 2'b10 || hold !== 1'b1) begin
      errors++;
      $display("FAIL left_hold: loc=%b hold=%b required 10/1", loc, hold);
    end
    // Rows change while SAMPLE is low; nothing may move.
    sample = 1'b0;
    set_rows(0, 8'h01, -1, 8'h00);
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (loc !== 2'b10 || hold !== 1'b1 || enter_r !== 1'b0 || enter_l !== 1'b0) begin
        errors++;
        $display("FAIL sample_low[%0d]: loc=%b hold=%b er=%b el=%b required 10/1/0/0",
                 i, loc, hold, enter_r, enter_l);
      end
    end
    clear  = 1'b1;
    sample = 1'b1;
    tick();
    checks++;
    if (loc !== 2'b00 || hold !== 1'b0 || enter_r !== 1'b0 || enter_l !== 1'b0) begin
      errors++;
      $display("FAIL clear: loc=%b hold=%b er=%b el=%b required 00/0/0/0",
               loc, hold, enter_r, enter_l);
    end
    clear = 1'b0;
    tick();
    checks++;
    if (loc !== 2'b01 || enter_r !== 1'b1 || hold !== 1'b0) begin
      errors++;
      $display("FAIL after_clear: loc=%b er=%b hold=%b required 01/1/0", loc, enter_r, hold);
    end
  endtask

`ifdef CC_COMPARATOR_SIDE_TRACKER_COLUMN_EN
  task automatic test_column();
    sample = 1'b1;
    set_rows(3, 8'h20, 11, 8'h04);
    tick();
    checks++;
    if (column !== 3'd2 || loc !== 2'b11) begin
      errors++;
      $display("FAIL column_24: column=%0d loc=%b required 2/11", column, loc);
    end
    set_rows(-1, 8'h00, -1, 8'h00);
    tick();
    checks++;
    if (column !== 3'd0 || loc !== 2'b00) begin
      errors++;
      $display("FAIL column_00: column=%0d loc=%b required 0/00", column, loc);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    sample = 1'b0;
    clear  = 1'b0;
    rows   = '0;
    #1;
    checks++;
    if (loc !== 2'b00 || hold !== 1'b0 || enter_r !== 1'b0 || enter_l !== 1'b0) begin
      errors++;
      $display("FAIL power_on_reset: loc=%b hold=%b er=%b el=%b required all 0",
               loc, hold, enter_r, enter_l);
    end
    tick();
    rst = 1'b0;
    tick();
    test_reset();
    test_right_dwell();
    test_middle();
    test_jump();
    test_sample_low_clear();
`ifdef CC_COMPARATOR_SIDE_TRACKER_COLUMN_EN
    test_column();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cc_comparator_side_tracker.md
Name: cc_comparator_side_tracker

Overview:
- Parametrised, registered successor to the Frog side-edge comparator.
- ORs NROWS Frog-matrix rows into one column-occupancy vector and classifies the Frog as empty, right edge, left edge or middle.
- Tracks how long the Frog stays at an edge with a 4-state FSM and a dwell counter. Emits edge-entry pulses and an edge-hold flag.
- Consumed by the game FSM for edge-push and kill decisions.

Parameters:
- DATAWIDTH_BUS, 8, columns per row (W); must be >= 2.
- NROWS, 14, number of matrix rows ORed together.
- DWELL_CYCLES, 3, consecutive edge samples required to assert hold; must be >= 1.

Ports:
- CC_COMPARATOR_SIDE_TRACKER_CLOCK_50  in  1  system clock; all state changes on its rising edge.
- CC_COMPARATOR_SIDE_TRACKER_RESET_InHigh  in  1  reset, asynchronous, active-high.
- CC_COMPARATOR_SIDE_TRACKER_SAMPLE_InHigh  in  1  sample strobe (frame tick); state updates only when high.
- CC_COMPARATOR_SIDE_TRACKER_CLEAR_InHigh  in  1  synchronous clear.
- CC_COMPARATOR_SIDE_TRACKER_ROWS_In_Bus  in  NROWS*DATAWIDTH_BUS  flattened rows; row r = bits [r*W +: W].
- CC_COMPARATOR_SIDE_TRACKER_LOCATION_Out_Bus  out  2  registered class: 00 empty, 01 right, 10 left, 11 middle.
- CC_COMPARATOR_SIDE_TRACKER_ENTER_RIGHT_Out  out  1  one-clock pulse on entry to right edge.
- CC_COMPARATOR_SIDE_TRACKER_ENTER_LEFT_Out  out  1  one-clock pulse on entry to left edge.
- CC_COMPARATOR_SIDE_TRACKER_HOLD_Out  out  1  high while the Frog has dwelt >= DWELL_CYCLES samples at the current edge.

Behaviour:
- Column occupancy and classification (combinational):
  - occ = bitwise OR of all NROWS rows.
  - occ == 0 -> EMPTY (00).
  - occ == 1 (only bit 0 set) -> RIGHT (01).
  - occ == 1<<(W-1) (only MSB set) -> LEFT (10).
  - Anything else, including multiple bits set, -> MIDDLE (11).
- FSM states: S_EMPTY, S_MIDDLE, S_RIGHT, S_LEFT. The state encoding equals the LOCATION code.
- Reset (async, dominates everything): state S_EMPTY, LOCATION 00, dwell counter 0, ENTER_* 0, HOLD 0.
- CLEAR high at a clock edge: same values as reset. CLEAR has priority over SAMPLE.
- SAMPLE high, CLEAR low:
  - state and LOCATION <= class. Latency is 1 clock from the sampled input to the output.
  - Dwell counter, width $clog2(DWELL_CYCLES+1):
    - class is an edge and equals the current state -> increment, saturating at DWELL_CYCLES.
    - class is an edge and differs from the current state -> load 1.
    - class is not an edge -> load 0.
  - ENTER_RIGHT <= (class==RIGHT && state!=S_RIGHT).
  - ENTER_LEFT <= (class==LEFT && state!=S_LEFT).
  - HOLD <= (next counter value == DWELL_CYCLES).
- SAMPLE low, CLEAR low: state, LOCATION, counter and HOLD hold their values; ENTER_* <= 0.
- ENTER_* are therefore never high for more than one clock, even when SAMPLE is held high continuously.
- Direct RIGHT->LEFT or LEFT->RIGHT jump: treated as a new entry. The ENTER pulse fires for the new edge, the counter reloads to 1, and HOLD drops unless DWELL_CYCLES==1.
- DWELL_CYCLES==1: HOLD rises in the same update as the ENTER pulse.
- Reset asserted mid-dwell: the counter is lost; after release, HOLD needs DWELL_CYCLES fresh samples at an edge.
- The counter never wraps; it stays at DWELL_CYCLES while the Frog remains at the edge.

Optional Feature:
- Macro: CC_COMPARATOR_SIDE_TRACKER_COLUMN_EN.
- Defined: adds output CC_COMPARATOR_SIDE_TRACKER_COLUMN_Out_Bus, width $clog2(DATAWIDTH_BUS).
  - Registered with the same SAMPLE/CLEAR/reset rules as LOCATION.
  - Value is the index of the lowest set bit of occ; 0 when occ==0.
  - Reset/CLEAR value is 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan (W=8, NROWS=14, DWELL_CYCLES=3):
- Reset asserted asynchronously mid-clock with rows nonzero -> all outputs 0 immediately; LOCATION 00 after release until the first SAMPLE.
- Row 5 = 8'h01, others 0; SAMPLE high 4 consecutive clocks -> LOCATION 01 after clock 1; ENTER_RIGHT high only after clock 1; HOLD high after clock 3 and stays high after clock 4.
- Row 2 = 8'h80, row 9 = 8'h01 (occ = 8'h81) -> LOCATION 11; no ENTER pulses; HOLD 0.
- Frog held at 8'h80 for 2 samples, then 8'h01 on the 3rd sample -> ENTER_LEFT pulse, then ENTER_RIGHT pulse, counter reloads to 1; HOLD stays 0 throughout.
- Frog at the left edge with HOLD=1; SAMPLE low for 10 clocks -> outputs unchanged, ENTER_* 0; then CLEAR and SAMPLE high together -> LOCATION 00, HOLD 0.
- COLUMN_EN defined, occ = 8'h24 -> COLUMN 2, LOCATION 11; occ = 8'h00 -> COLUMN 0, LOCATION 00.
